// File: rtl/motor_ramp_ctrl.sv
// Purpose: ramps left/right motor speed and direction toward commanded targets for the PWM stage.
// Latency: command accepted in one clock; speed moves one RAMP_STEP per RAMP_DIV-clock tick.
// Backpressure: cmd_ready drops only while estop is high or the block is halted.
module motor_ramp_ctrl #(
  parameter int MAX_SPEED = 11000,
  parameter int RAMP_DIV  = 11000,
  parameter int RAMP_STEP = 500
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_dir_l,
  input  logic        i_cmd_dir_r,
  input  logic [13:0] i_cmd_speed_l,
  input  logic [13:0] i_cmd_speed_r,
  input  logic        i_estop,
  output logic        o_dir_l,
  output logic        o_dir_r,
  output logic [13:0] o_speed_l,
  output logic [13:0] o_speed_r,
  output logic        o_busy
);

  localparam logic [13:0] MAX14  = 14'(MAX_SPEED);
  localparam logic [13:0] STEP14 = 14'(RAMP_STEP);
  localparam logic [14:0] STEP15 = 15'(RAMP_STEP);
  localparam logic [15:0] DIV_M1 = 16'(RAMP_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DECEL = 2'd1,
    ST_ACCEL = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_presc, w_presc_nxt;
  logic [13:0] r_speed_l, r_speed_r, w_speed_l_nxt, w_speed_r_nxt;
  logic [13:0] r_tgt_l, r_tgt_r, w_tgt_l_nxt, w_tgt_r_nxt;
  logic        r_dir_l, r_dir_r, w_dir_l_nxt, w_dir_r_nxt;
  logic        r_tgt_dir_l, r_tgt_dir_r, w_tgt_dir_l_nxt, w_tgt_dir_r_nxt;
  logic        r_busy;

  logic        w_tick;
  logic        w_accept;
  logic        w_rev_l, w_rev_r;
  logic [13:0] w_eff_l, w_eff_r;
  logic [13:0] w_ramp_l, w_ramp_r;
  logic [13:0] w_sat_l, w_sat_r;

  // One ramp step toward eff; differences are taken in 15 bits so nothing wraps
  // and the result lands exactly on eff when within one step of it.
  function automatic logic [13:0] f_step(input logic [13:0] spd, input logic [13:0] eff);
    logic [13:0] res;
    res = spd;
    if (spd < eff) begin
      res = (({1'b0, eff} - {1'b0, spd}) <= STEP15) ? eff : spd + STEP14;
    end else if (spd > eff) begin
      res = (({1'b0, spd} - {1'b0, eff}) <= STEP15) ? eff : spd - STEP14;
    end
    return res;
  endfunction

  assign o_cmd_ready = !i_estop && (r_state != ST_HALT);
  assign w_accept    = i_cmd_valid && o_cmd_ready;
  assign w_tick      = (r_presc == DIV_M1);

  // A side whose latched direction differs from its live direction must reach 0 first.
  assign w_rev_l  = (r_tgt_dir_l != r_dir_l);
  assign w_rev_r  = (r_tgt_dir_r != r_dir_r);
  assign w_eff_l  = w_rev_l ? 14'd0 : r_tgt_l;
  assign w_eff_r  = w_rev_r ? 14'd0 : r_tgt_r;
  assign w_ramp_l = w_tick ? f_step(r_speed_l, w_eff_l) : r_speed_l;
  assign w_ramp_r = w_tick ? f_step(r_speed_r, w_eff_r) : r_speed_r;
  assign w_sat_l  = (i_cmd_speed_l > MAX14) ? MAX14 : i_cmd_speed_l;
  assign w_sat_r  = (i_cmd_speed_r > MAX14) ? MAX14 : i_cmd_speed_r;

  // Next-state and datapath: estop wins, then command accept, then per-state progress.
  always_comb begin
    w_state_nxt     = r_state;
    w_speed_l_nxt   = w_ramp_l;
    w_speed_r_nxt   = w_ramp_r;
    w_dir_l_nxt     = r_dir_l;
    w_dir_r_nxt     = r_dir_r;
    w_tgt_l_nxt     = r_tgt_l;
    w_tgt_r_nxt     = r_tgt_r;
    w_tgt_dir_l_nxt = r_tgt_dir_l;
    w_tgt_dir_r_nxt = r_tgt_dir_r;
    w_presc_nxt     = w_tick ? 16'd0 : r_presc + 16'd1;

    if (i_estop) begin
      w_state_nxt     = ST_HALT;
      w_speed_l_nxt   = 14'd0;
      w_speed_r_nxt   = 14'd0;
      w_tgt_l_nxt     = 14'd0;
      w_tgt_r_nxt     = 14'd0;
      w_tgt_dir_l_nxt = r_dir_l;
      w_tgt_dir_r_nxt = r_dir_r;
      w_presc_nxt     = 16'd0;
    end else if (r_state == ST_HALT) begin
      w_state_nxt   = ST_IDLE;
      w_speed_l_nxt = 14'd0;
      w_speed_r_nxt = 14'd0;
      w_presc_nxt   = 16'd0;
    end else if (w_accept) begin
      // Ramp on this edge still uses the old targets; new ones take effect next tick.
      w_tgt_l_nxt     = w_sat_l;
      w_tgt_r_nxt     = w_sat_r;
      w_tgt_dir_l_nxt = i_cmd_dir_l;
      w_tgt_dir_r_nxt = i_cmd_dir_r;
      if (r_speed_l == 14'd0) w_dir_l_nxt = i_cmd_dir_l;
      if (r_speed_r == 14'd0) w_dir_r_nxt = i_cmd_dir_r;
      if (((i_cmd_dir_l != r_dir_l) && (r_speed_l != 14'd0)) ||
          ((i_cmd_dir_r != r_dir_r) && (r_speed_r != 14'd0))) begin
        w_state_nxt = ST_DECEL;
      end else begin
        w_state_nxt = ST_ACCEL;
      end
    end else begin
      case (r_state)
        ST_DECEL: begin
          if ((!w_rev_l || (r_speed_l == 14'd0)) && (!w_rev_r || (r_speed_r == 14'd0))) begin
            w_dir_l_nxt = r_tgt_dir_l;
            w_dir_r_nxt = r_tgt_dir_r;
            w_state_nxt = ST_ACCEL;
          end
        end
        ST_ACCEL: begin
          if ((r_speed_l == r_tgt_l) && (r_speed_r == r_tgt_r)) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  // FSM state register and busy flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Speed, direction, target and prescaler registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc     <= 16'd0;
      r_speed_l   <= 14'd0;
      r_speed_r   <= 14'd0;
      r_dir_l     <= 1'b0;
      r_dir_r     <= 1'b0;
      r_tgt_l     <= 14'd0;
      r_tgt_r     <= 14'd0;
      r_tgt_dir_l <= 1'b0;
      r_tgt_dir_r <= 1'b0;
    end else begin
      r_presc     <= w_presc_nxt;
      r_speed_l   <= w_speed_l_nxt;
      r_speed_r   <= w_speed_r_nxt;
      r_dir_l     <= w_dir_l_nxt;
      r_dir_r     <= w_dir_r_nxt;
      r_tgt_l     <= w_tgt_l_nxt;
      r_tgt_r     <= w_tgt_r_nxt;
      r_tgt_dir_l <= w_tgt_dir_l_nxt;
      r_tgt_dir_r <= w_tgt_dir_r_nxt;
    end
  end

  assign o_dir_l   = r_dir_l;
  assign o_dir_r   = r_dir_r;
  assign o_speed_l = r_speed_l;
  assign o_speed_r = r_speed_r;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Purpose: directed table-driven bench for motor_ramp_ctrl with small ramp parameters.
// Latency: each table row applies inputs for one clock then idles for the rest of its cycles.
// Backpressure: cmd_ready is compared every row, including rows held in estop.
module tb_motor_ramp_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir_l, cmd_dir_r;
  logic [13:0] cmd_speed_l, cmd_speed_r;
  logic        estop;
  logic        dir_l, dir_r;
  logic [13:0] speed_l, speed_r;
  logic        busy;

  int n_pass = 0;
  int n_tot  = 0;

  motor_ramp_ctrl #(.MAX_SPEED(20), .RAMP_DIV(4), .RAMP_STEP(3)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_dir_l  (cmd_dir_l),
    .i_cmd_dir_r  (cmd_dir_r),
    .i_cmd_speed_l(cmd_speed_l),
    .i_cmd_speed_r(cmd_speed_r),
    .i_estop      (estop),
    .o_dir_l      (dir_l),
    .o_dir_r      (dir_r),
    .o_speed_l    (speed_l),
    .o_speed_r    (speed_r),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic vld;
    logic dl;
    logic dr;
    int   sl;
    int   sr;
    logic es;
    int   cyc;
    logic e_dl;
    logic e_dr;
    int   e_sl;
    int   e_sr;
    logic e_busy;
    logic e_rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic vld, logic dl, logic dr, int sl, int sr, logic es, int cyc,
                              logic e_dl, logic e_dr, int e_sl, int e_sr, logic e_busy, logic e_rdy);
    vec_t v;
    v.vld = vld; v.dl = dl; v.dr = dr; v.sl = sl; v.sr = sr; v.es = es; v.cyc = cyc;
    v.e_dl = e_dl; v.e_dr = e_dr; v.e_sl = e_sl; v.e_sr = e_sr; v.e_busy = e_busy; v.e_rdy = e_rdy;
    return v;
  endfunction

  function automatic vec_t idl(int cyc, logic e_dl, logic e_dr, int e_sl, int e_sr, logic e_busy);
    return mk(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, cyc, e_dl, e_dr, e_sl, e_sr, e_busy, 1'b1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Accept 10/10 forward from rest: 3,6,9,10 one step per 4 clocks.
    tbl.push_back(mk(1, 1, 1, 10, 10, 0, 1, 1, 1, 0, 0, 1, 1));
    tbl.push_back(idl(2, 1, 1, 0, 0, 1));
    tbl.push_back(idl(1, 1, 1, 3, 3, 1));
    tbl.push_back(idl(3, 1, 1, 3, 3, 1));
    tbl.push_back(idl(1, 1, 1, 6, 6, 1));
    tbl.push_back(idl(4, 1, 1, 9, 9, 1));
    tbl.push_back(idl(4, 1, 1, 10, 10, 1));
    tbl.push_back(idl(1, 1, 1, 10, 10, 0));
    // Reverse left to 6: 7,4,1,0, flip one clock later, then 3,6; right untouched.
    tbl.push_back(mk(1, 0, 1, 6, 10, 0, 1, 1, 1, 10, 10, 1, 1));
    tbl.push_back(idl(2, 1, 1, 7, 10, 1));
    tbl.push_back(idl(4, 1, 1, 4, 10, 1));
    tbl.push_back(idl(4, 1, 1, 1, 10, 1));
    tbl.push_back(idl(4, 1, 1, 0, 10, 1));
    tbl.push_back(idl(1, 0, 1, 0, 10, 1));
    tbl.push_back(idl(3, 0, 1, 3, 10, 1));
    tbl.push_back(idl(4, 0, 1, 6, 10, 1));
    tbl.push_back(idl(1, 0, 1, 6, 10, 0));
    // Left 30 saturates to 20; right steps down to 5 and holds.
    tbl.push_back(mk(1, 0, 1, 30, 5, 0, 1, 0, 1, 6, 10, 1, 1));
    tbl.push_back(idl(2, 0, 1, 9, 7, 1));
    tbl.push_back(idl(4, 0, 1, 12, 5, 1));
    tbl.push_back(idl(4, 0, 1, 15, 5, 1));
    tbl.push_back(idl(4, 0, 1, 18, 5, 1));
    tbl.push_back(idl(4, 0, 1, 20, 5, 1));
    tbl.push_back(idl(1, 0, 1, 20, 5, 0));
    // Target 0 with matching dirs: plain ramp down, no dir change.
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0, 1, 20, 5, 1, 1));
    tbl.push_back(idl(2, 0, 1, 17, 2, 1));
    tbl.push_back(idl(4, 0, 1, 14, 0, 1));
    tbl.push_back(idl(20, 0, 1, 0, 0, 1));
    tbl.push_back(idl(1, 0, 1, 0, 0, 0));
    // Ramp toward 20, retarget to 5 on a tick edge: tick uses old target (9), then 6, 5.
    tbl.push_back(mk(1, 0, 1, 20, 0, 0, 1, 0, 1, 0, 0, 1, 1));
    tbl.push_back(idl(9, 0, 1, 6, 0, 1));
    tbl.push_back(mk(1, 0, 1, 5, 0, 0, 1, 0, 1, 9, 0, 1, 1));
    tbl.push_back(idl(4, 0, 1, 6, 0, 1));
    tbl.push_back(idl(4, 0, 1, 5, 0, 1));
    tbl.push_back(idl(1, 0, 1, 5, 0, 0));
    // Estop mid-ramp with cmd_valid held: zero at once, dirs hold, then release to IDLE.
    tbl.push_back(mk(1, 0, 1, 20, 20, 0, 1, 0, 1, 5, 0, 1, 1));
    tbl.push_back(idl(2, 0, 1, 8, 3, 1));
    tbl.push_back(mk(1, 1, 0, 7, 7, 1, 1, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 7, 7, 1, 1, 0, 1, 0, 0, 1, 0));
    tbl.push_back(idl(1, 0, 1, 0, 0, 0));
    tbl.push_back(idl(4, 0, 1, 0, 0, 0));

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_dir_l = 1'b0; cmd_dir_r = 1'b0;
    cmd_speed_l = '0; cmd_speed_r = '0; estop = 1'b0;
    #3;
    chk("reset speed_l", int'(speed_l), 0);
    chk("reset speed_r", int'(speed_r), 0);
    chk("reset dir_l", int'(dir_l), 0);
    chk("reset dir_r", int'(dir_r), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset cmd_ready", int'(cmd_ready), 1);
    #9 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cmd_valid   = tbl[i].vld;
      cmd_dir_l   = tbl[i].dl;
      cmd_dir_r   = tbl[i].dr;
      cmd_speed_l = 14'(tbl[i].sl);
      cmd_speed_r = 14'(tbl[i].sr);
      estop       = tbl[i].es;
      for (int c = 0; c < tbl[i].cyc; c++) begin
        clk1();
        cmd_valid = 1'b0;
      end
      chk($sformatf("row%0d speed_l", i), int'(speed_l), tbl[i].e_sl);
      chk($sformatf("row%0d speed_r", i), int'(speed_r), tbl[i].e_sr);
      chk($sformatf("row%0d dir_l", i), int'(dir_l), int'(tbl[i].e_dl));
      chk($sformatf("row%0d dir_r", i), int'(dir_r), int'(tbl[i].e_dr));
      chk($sformatf("row%0d busy", i), int'(busy), int'(tbl[i].e_busy));
      chk($sformatf("row%0d cmd_ready", i), int'(cmd_ready), int'(tbl[i].e_rdy));
    end
    estop = 1'b0;

    // Settle at 9/9 dirs 0/1, then reverse both to enter DECEL.
    cmd_valid = 1'b1; cmd_dir_l = 1'b0; cmd_dir_r = 1'b1;
    cmd_speed_l = 14'd9; cmd_speed_r = 14'd9;
    clk1();
    cmd_valid = 1'b0;
    repeat (20) clk1();
    chk("settle speed_l", int'(speed_l), 9);
    chk("settle speed_r", int'(speed_r), 9);
    chk("settle busy", int'(busy), 0);
    cmd_valid = 1'b1; cmd_dir_l = 1'b1; cmd_dir_r = 1'b0;
    clk1();
    cmd_valid = 1'b0;
    repeat (5) clk1();
    chk("decel busy", int'(busy), 1);
    chk("decel dir_l held", int'(dir_l), 0);
    chk("decel dir_r held", int'(dir_r), 1);
    chk("decel speed_l nonzero", int'(speed_l != 14'd0), 1);

    // Asynchronous reset pulse between clock edges.
    #3 rst_n = 1'b0;
    #1;
    chk("arst speed_l", int'(speed_l), 0);
    chk("arst speed_r", int'(speed_r), 0);
    chk("arst dir_r", int'(dir_r), 0);
    chk("arst busy", int'(busy), 0);
    #2 rst_n = 1'b1;
    repeat (3) clk1();
    chk("post-reset busy", int'(busy), 0);
    chk("post-reset speed_l", int'(speed_l), 0);
    chk("post-reset dir_l", int'(dir_l), 0);
    chk("post-reset cmd_ready", int'(cmd_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
